// File: rtl/riscv_mem_pkg.sv
// Shared types for the memory port arbiter: FSM states, requester
// encoding and the default bus widths.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } owner_t;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/mem_arb_fairness.sv
// Picks the winning requester and tracks how many data grants were given
// while fetch was waiting, so fetch cannot be starved.
module mem_arb_fairness
  import riscv_mem_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int STREAK_W     = $clog2(MAX_D_STREAK + 1)
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   if_valid,
  input  logic   d_valid,
  input  logic   accept,
  input  owner_t owner,
  output owner_t winner
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] streak;

  always_comb begin
    winner = OWNER_D;
    if (if_valid && (!d_valid || streak == STREAK_MAX)) begin
      winner = OWNER_IF;
    end
  end

  // Only data grants that made fetch wait count toward the streak.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak <= '0;
    end else if (accept) begin
      if (owner == OWNER_IF) begin
        streak <= '0;
      end else if (if_valid && streak != STREAK_MAX) begin
        streak <= streak + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction
// fetch and the load/store path, one outstanding transaction at a time.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rsp_data,
  output logic                m_req_valid,
  input  logic                m_req_ready,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_rsp_valid,
  input  logic [DATA_W-1:0]   m_rsp_data,
  output logic                busy,
  output logic                protocol_err
);

  arb_state_t state, state_next;
  owner_t     owner, winner;
  logic       accept;

  assign accept = if_req_ready | d_req_ready;

  mem_arb_fairness #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_fairness (
    .clk      (clk),
    .reset    (reset),
    .if_valid (if_req_valid),
    .d_valid  (d_req_valid),
    .accept   (accept),
    .owner    (winner),
    .winner   (winner)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A response outside WAIT is ignored here; it only raises protocol_err.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept)      state_next = ISSUE;
      ISSUE:   if (m_req_ready) state_next = WAIT;
      WAIT:    if (m_rsp_valid) state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Readys are forced low while reset is held so nothing is accepted then.
  always_comb begin
    if_req_ready = 1'b0;
    d_req_ready  = 1'b0;
    m_req_valid  = (state == ISSUE);
    busy         = (state != IDLE);
    if (reset && state == IDLE) begin
      if_req_ready = if_req_valid && (winner == OWNER_IF);
      d_req_ready  = d_req_valid  && (winner == OWNER_D);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner   <= OWNER_IF;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_wstrb <= '0;
    end else if (accept) begin
      owner <= winner;
      if (winner == OWNER_IF) begin
        m_we    <= 1'b0;
        m_addr  <= if_addr;
        m_wdata <= '0;
        m_wstrb <= '0;
      end else begin
        m_we    <= d_we;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
        m_wstrb <= d_wstrb;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      d_rsp_valid  <= 1'b0;
      d_rsp_data   <= '0;
      protocol_err <= 1'b0;
    end else begin
      if_rsp_valid <= (state == WAIT) && m_rsp_valid && (owner == OWNER_IF);
      d_rsp_valid  <= (state == WAIT) && m_rsp_valid && (owner == OWNER_D);
      if (state == WAIT && m_rsp_valid) begin
        if (owner == OWNER_IF) begin
          if_rsp_data <= m_rsp_data;
        end else begin
          d_rsp_data <= m_we ? '0 : m_rsp_data;
        end
      end
      if (m_rsp_valid && state != WAIT) begin
        protocol_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: responses are checked against a
// scoreboard filled at each accepted request.
module tb_mem_port_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int MAX_D_STREAK = 4;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } rsp_t;

  logic                clk;
  logic                reset;
  logic                if_req_valid;
  logic                if_req_ready;
  logic [ADDR_W-1:0]   if_addr;
  logic                if_rsp_valid;
  logic [DATA_W-1:0]   if_rsp_data;
  logic                d_req_valid;
  logic                d_req_ready;
  logic                d_we;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic [DATA_W/8-1:0] d_wstrb;
  logic                d_rsp_valid;
  logic [DATA_W-1:0]   d_rsp_data;
  logic                m_req_valid;
  logic                m_req_ready;
  logic                m_we;
  logic [ADDR_W-1:0]   m_addr;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;
  logic                m_rsp_valid;
  logic [DATA_W-1:0]   m_rsp_data;
  logic                busy;
  logic                protocol_err;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   model_streak = 0;
  rsp_t sb[$];

  mem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .MAX_D_STREAK(MAX_D_STREAK)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_addr      (if_addr),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_data  (if_rsp_data),
    .d_req_valid  (d_req_valid),
    .d_req_ready  (d_req_ready),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_wstrb      (d_wstrb),
    .d_rsp_valid  (d_rsp_valid),
    .d_rsp_data   (d_rsp_data),
    .m_req_valid  (m_req_valid),
    .m_req_ready  (m_req_ready),
    .m_we         (m_we),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_wstrb      (m_wstrb),
    .m_rsp_valid  (m_rsp_valid),
    .m_rsp_data   (m_rsp_data),
    .busy         (busy),
    .protocol_err (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_cnt++;
    assert (observed === expected) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every requester response pulse must match the oldest accepted request.
  always @(negedge clk) begin
    if (if_rsp_valid || d_rsp_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_rsp", 32'({if_rsp_valid, d_rsp_valid}), 32'd0);
      end else begin
        rsp_t exp_rsp;
        exp_rsp = sb.pop_front();
        checkOutput("rsp_owner", 32'({if_rsp_valid, d_rsp_valid}),
                    exp_rsp.is_d ? 32'd1 : 32'd2);
        checkOutput("rsp_data", exp_rsp.is_d ? d_rsp_data : if_rsp_data, exp_rsp.data);
      end
    end
  end

  // Plays the memory side starting in the ISSUE cycle; ends in the cycle
  // after the response, where the arbiter is back in IDLE.
  task automatic runMem(input int stall, input logic [31:0] rdata);
    int          guard;
    logic [31:0] a, w;
    logic [3:0]  s;
    logic        we;
    guard = 0;
    while (!m_req_valid && guard < 20) begin
      tick();
      guard++;
    end
    checkOutput("m_req_valid_seen", 32'(m_req_valid), 32'd1);
    a  = m_addr;
    w  = m_wdata;
    s  = m_wstrb;
    we = m_we;
    for (int i = 0; i < stall; i++) begin
      m_req_ready = 1'b0;
      tick();
      checkOutput("stall_addr", m_addr, a);
      checkOutput("stall_wdata", m_wdata, w);
      checkOutput("stall_wstrb_we", 32'({m_wstrb, m_we}), 32'({s, we}));
      checkOutput("stall_valid_busy", 32'({m_req_valid, busy}), 32'd3);
      checkOutput("stall_readys", 32'({if_req_ready, d_req_ready}), 32'd0);
    end
    m_req_ready = 1'b1;
    tick();
    m_req_ready = 1'b0;
    checkOutput("wait_busy", 32'({busy, m_req_valid}), 32'd2);
    m_rsp_valid = 1'b1;
    m_rsp_data  = rdata;
    tick();
    m_rsp_valid = 1'b0;
    m_rsp_data  = $urandom;
    checkOutput("idle_busy", 32'(busy), 32'd0);
  endtask

  // Drives one arbitration round, checks the winner against the streak
  // model and the latched fields, then completes the transaction.
  task automatic applyStimulus(input logic want_if, input logic want_d,
                               input logic store, input logic [31:0] addr,
                               input int stall, input logic [31:0] rdata);
    logic        exp_if;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;
    if_req_valid = want_if;
    d_req_valid  = want_d;
    if_addr      = addr;
    d_addr       = addr ^ 32'h0000_0100;
    d_we         = store;
    d_wdata      = store ? 32'h1234_5678 : (32'hA5A5_0000 | addr);
    d_wstrb      = store ? 4'hF : 4'h3;
    #1;
    exp_if = want_if && (!want_d || model_streak == MAX_D_STREAK);
    checkOutput("if_req_ready", 32'(if_req_ready), 32'(exp_if));
    checkOutput("d_req_ready", 32'(d_req_ready), 32'(!exp_if && want_d));
    if (exp_if) model_streak = 0;
    else if (want_if && model_streak < MAX_D_STREAK) model_streak++;
    sb.push_back('{is_d: !exp_if, data: (!exp_if && store) ? 32'd0 : rdata});
    exp_addr  = exp_if ? if_addr : d_addr;
    exp_wdata = d_wdata;
    exp_wstrb = exp_if ? 4'h0 : d_wstrb;
    tick();
    d_wdata = 32'hFFFF_FFFF;
    d_wstrb = 4'h0;
    checkOutput("m_req_valid", 32'(m_req_valid), 32'd1);
    checkOutput("m_addr", m_addr, exp_addr);
    checkOutput("m_we_wstrb", 32'({m_wstrb, m_we}), 32'({exp_wstrb, !exp_if && store}));
    if (!exp_if) checkOutput("m_wdata", m_wdata, exp_wdata);
    runMem(stall, rdata);
  endtask

  initial begin
    reset        = 1'b0;
    if_req_valid = 1'b0;
    if_addr      = '0;
    d_req_valid  = 1'b1;
    d_we         = 1'b0;
    d_addr       = '0;
    d_wdata      = '0;
    d_wstrb      = '0;
    m_req_ready  = 1'b0;
    m_rsp_valid  = 1'b0;
    m_rsp_data   = '0;
    #12;
    checkOutput("reset_readys", 32'({if_req_ready, d_req_ready}), 32'd0);
    checkOutput("reset_flags", 32'({busy, m_req_valid, protocol_err, if_rsp_valid, d_rsp_valid}), 32'd0);
    checkOutput("reset_fields", m_addr | m_wdata | 32'({m_wstrb, m_we}), 32'd0);
    checkOutput("reset_rsp_data", if_rsp_data | d_rsp_data, 32'd0);
    d_req_valid = 1'b0;
    reset = 1'b1;
    tick();

    $display("[TB] single load, zero-wait memory");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0140, 0, 32'hDEAD_BEEF);
    d_req_valid = 1'b0;
    checkOutput("load_rsp_at_t3", 32'({if_rsp_valid, d_rsp_valid}), 32'd1);
    checkOutput("load_rsp_data", d_rsp_data, 32'hDEAD_BEEF);

    $display("[TB] store with backpressure");
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0180, 3, 32'hCAFE_F00D);
    d_req_valid = 1'b0;
    checkOutput("store_rsp_data", d_rsp_data, 32'd0);

    $display("[TB] starvation guard");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_1000 + 32'(i * 8), 0, 32'hC0DE_0000 + 32'(i));
    end

    $display("[TB] fetch alone, then both");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0000, 0, 32'h0000_0013);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_2000, 0, 32'h1111_0001);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_2008, 0, 32'h1111_0002);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_2010, 0, 32'h1111_0003);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_2018, 1, 32'h1111_0004);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_2020, 0, 32'h1111_0005);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_2028, 0, 32'h1111_0006);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_2030, 2, 32'h1111_0007);
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    tick();

    $display("[TB] spurious response while idle");
    m_rsp_valid = 1'b1;
    m_rsp_data  = 32'h5555_AAAA;
    tick();
    m_rsp_valid = 1'b0;
    checkOutput("spurious_err", 32'({protocol_err, busy}), 32'd2);
    tick();
    tick();
    checkOutput("spurious_err_sticky", 32'(protocol_err), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_3000, 0, 32'h7777_0001);
    d_req_valid = 1'b0;
    checkOutput("after_spurious_rsp", 32'({d_rsp_valid, protocol_err}), 32'd3);

    $display("[TB] reset during wait");
    d_req_valid = 1'b1;
    d_we        = 1'b0;
    d_addr      = 32'h0000_0300;
    #1;
    checkOutput("rst_case_accept", 32'(d_req_ready), 32'd1);
    tick();
    d_req_valid = 1'b0;
    m_req_ready = 1'b1;
    tick();
    m_req_ready = 1'b0;
    checkOutput("rst_case_in_wait", 32'(busy), 32'd1);
    #1 reset = 1'b0;
    #1;
    model_streak = 0;
    checkOutput("rst_async_flags", 32'({busy, m_req_valid, protocol_err, if_rsp_valid, d_rsp_valid}), 32'd0);
    checkOutput("rst_async_fields", m_addr | m_wdata | 32'({m_wstrb, m_we}), 32'd0);
    tick();
    reset = 1'b1;
    #1;
    checkOutput("rst_idle_after", 32'(busy), 32'd0);
    m_rsp_valid = 1'b1;
    m_rsp_data  = 32'h0BAD_0BAD;
    tick();
    m_rsp_valid = 1'b0;
    checkOutput("late_rsp_err", 32'({protocol_err, busy}), 32'd2);
    tick();
    tick();
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, variable-latency memory between the instruction fetch unit and the load/store datapath. Accepts one request at a time from either requester and forwards it downstream. Routes the memory's response back to the requester that issued it. Data accesses have priority, and a streak counter guarantees that instruction fetch cannot starve.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- MAX_D_STREAK, 4, consecutive data grants allowed while fetch is waiting (≥1)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted
- if_addr  in  ADDR_W  fetch address
- if_rsp_valid  out  1  fetch data valid (one-cycle pulse)
- if_rsp_data  out  DATA_W  fetched instruction
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wstrb  in  DATA_W/8  byte enables for stores
- d_rsp_valid  out  1  load data or store acknowledge (one-cycle pulse)
- d_rsp_data  out  DATA_W  load data; 0 for stores
- m_req_valid  out  1  downstream request
- m_req_ready  in  1  downstream accepted
- m_we, m_addr, m_wdata, m_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  latched request fields
- m_rsp_valid  in  1  downstream response (exactly one per accepted request, including stores)
- m_rsp_data  in  DATA_W  downstream read data
- busy  out  1  state ≠ IDLE
- protocol_err  out  1  sticky flag: m_rsp_valid received outside WAIT

## Operation
- Reset values:
  - state = IDLE
  - all ready, valid, busy and protocol_err outputs = 0
  - all latched fields and response data outputs = 0
  - streak = 0, owner = IF
- **IDLE:**
  - if_req_ready and d_req_ready are combinational. Only the winner sees ready = 1.
  - Winner rule: data wins unless fetch is also valid and streak == MAX_D_STREAK, in which case fetch wins.
  - On accept: latch owner and the request fields (a fetch latches we = 0, wstrb = 0), then go to ISSUE.
- **ISSUE:**
  - m_req_valid = 1 and the latched fields are held stable.
  - On m_req_ready = 1, go to WAIT.
  - Both requester readys = 0.
- **WAIT:**
  - On m_rsp_valid = 1, register a response toward the owner:
    - *_rsp_valid = 1 for the next cycle only.
    - rsp_data = m_rsp_data, or 0 if the request was a store.
  - Go to IDLE.
- **Streak counter:**
  - A data grant while if_req_valid = 1 increments streak, saturating at MAX_D_STREAK.
  - A data grant with fetch idle leaves streak unchanged.
  - A fetch grant clears streak.
- **protocol_err:** set when m_rsp_valid = 1 in IDLE or ISSUE. That response is discarded and the state is unchanged. Cleared only by reset.
- **Reset mid-transaction:** the outstanding request is dropped with no response, and no pending response pulse is emitted.

## Timing
- Accept at edge T → m_req_valid high in cycle T+1.
- If m_req_ready = 1 in T+1 → WAIT from T+2.
- m_rsp_valid in cycle R → owner *_rsp_valid high in R+1. The state is IDLE in R+1 and may accept a new request in that same cycle.
- Minimum cost: 3 cycles per transaction with zero-wait memory.
- Requester inputs are sampled only at the accept edge. Changes afterward have no effect.
- At most one transaction is outstanding. Responses therefore cannot reorder.

## Structure
- Shared package `riscv_mem_pkg` holds:
  - the state enum: IDLE, ISSUE, WAIT
  - the owner encoding: OWNER_IF = 0, OWNER_D = 1
  - the default ADDR_W and DATA_W
- One sub-module, `mem_arb_fairness`: takes both valids, accept and owner; outputs the winner and holds the streak counter.
- The FSM, latches and response register stay in the top module.

## Test plan
1. **Single load, zero-wait memory.** d_req with we = 0, addr = 0x40; memory returns 0xDEADBEEF. Required:
   - d_req_ready at T
   - m_req_valid and m_addr = 0x40 at T+1
   - d_rsp_valid with 0xDEADBEEF at T+3
   - if_rsp_valid never asserted
2. **Store with backpressure.** Hold m_req_ready = 0 for 3 cycles, store wdata = 0x12345678, wstrb = 0xF. Required:
   - m_* fields stable through the stall
   - d_rsp_valid pulse with data 0
   - busy high from T+1 until the response cycle
3. **Starvation guard.** Both requesters valid continuously, MAX_D_STREAK = 4. Required grant order: D, D, D, D, IF, D, D, D, D, IF…
4. **Simultaneous request when fetch is alone.** Only if_req_valid, addr = 0x0 → fetch granted and streak stays 0. Then both valid → data granted.
5. **Spurious response.** m_rsp_valid pulse while IDLE. Required:
   - protocol_err = 1 and remains set
   - no rsp_valid to either requester
   - next request completes normally
6. **Reset during WAIT.** Assert reset before m_rsp_valid. Required:
   - all outputs = 0 immediately (asynchronous)
   - state IDLE after release
   - a late response sets protocol_err and produces no requester pulse
